// File: rtl/tracker_pkg.sv
// Shared types and default widths for the chroma centroid tracker.
// Default widths are derived from the largest supported frame.
package tracker_pkg;

  localparam int unsigned FRAME_W = 1280;
  localparam int unsigned FRAME_H = 720;

  localparam int unsigned H_WIDTH_D   = $clog2(FRAME_W);
  localparam int unsigned V_WIDTH_D   = $clog2(FRAME_H);
  localparam int unsigned CNT_WIDTH_D = $clog2(FRAME_W * FRAME_H + 1);
  localparam int unsigned SUM_WIDTH_D = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } tracker_state_t;

endpackage

// File: rtl/centroid_divider.sv
// Restoring unsigned divider that produces one quotient bit per cycle.
// It captures its operands on start_in and pulses done_out WIDTH+1 cycles later.
module centroid_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic             done_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // The shifted remainder is below 2*divisor, so a clear top bit means no borrow.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_rem   <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quot  <= {r_quot[WIDTH-2:0], w_ge};
        r_count <= r_count - CW'(1);
        if (r_count == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start_in) begin
        r_rem   <= '0;
        r_quot  <= dividend_in;
        r_div   <= divisor_in;
        r_count <= CW'(WIDTH);
        r_busy  <= 1'b1;
      end
    end
  end

  assign quotient_out = r_quot;
  assign done_out     = r_done;

endmodule

// File: rtl/chroma_centroid_tracker.sv
// Chroma-keyed mask, per-frame coordinate accumulation and centroid division.
// One centroid result is produced per frame boundary seen while idle.
module chroma_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned H_WIDTH   = H_WIDTH_D,
  parameter int unsigned V_WIDTH   = V_WIDTH_D,
  parameter int unsigned SUM_WIDTH = SUM_WIDTH_D,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_D
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic [7:0]         y_in,
  input  logic [7:0]         cr_in,
  input  logic [7:0]         cb_in,
  input  logic               new_frame_in,
  input  logic [7:0]         cr_lo_in,
  input  logic [7:0]         cr_hi_in,
  input  logic [7:0]         y_min_in,
  output logic               mask_out,
  output logic [H_WIDTH-1:0] x_out,
  output logic [V_WIDTH-1:0] y_out,
  output logic               found_out,
  output logic               centroid_valid_out,
  output logic               busy_out,
  output logic               overrun_out
);

  tracker_state_t r_state;
  tracker_state_t w_state_nxt;

  logic [SUM_WIDTH-1:0] r_sum_x;
  logic [SUM_WIDTH-1:0] r_sum_y;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_div_path;

  logic                 w_mask;
  logic [SUM_WIDTH-1:0] w_add_x;
  logic [SUM_WIDTH-1:0] w_add_y;
  logic [SUM_WIDTH-1:0] w_divisor;
  logic [SUM_WIDTH-1:0] w_quot_x;
  logic [SUM_WIDTH-1:0] w_quot_y;
  logic                 w_done_x;
  logic                 w_done_y;
  logic                 w_div_start;
  logic                 w_empty_start;
  logic                 w_publish;
  logic                 w_unused;

  assign w_mask = valid_in & (cr_in >= cr_lo_in) & (cr_in <= cr_hi_in) & (y_in >= y_min_in);

  assign w_add_x   = SUM_WIDTH'(hcount_in);
  assign w_add_y   = SUM_WIDTH'(vcount_in);
  assign w_divisor = SUM_WIDTH'(r_cnt);
  assign w_unused  = ^{cb_in, w_quot_x[SUM_WIDTH-1:H_WIDTH], w_quot_y[SUM_WIDTH-1:V_WIDTH]};

  // A masked pixel coincident with the frame pulse seeds the new frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (new_frame_in) begin
      r_sum_x <= w_mask ? w_add_x : '0;
      r_sum_y <= w_mask ? w_add_y : '0;
      r_cnt   <= w_mask ? CNT_WIDTH'(1) : '0;
    end else if (w_mask) begin
      r_sum_x <= r_sum_x + w_add_x;
      r_sum_y <= r_sum_y + w_add_y;
      r_cnt   <= r_cnt + CNT_WIDTH'(1);
    end
  end

  // The dividers latch the pre-update sums, acting as the frame snapshot.
  centroid_divider #(.WIDTH(SUM_WIDTH)) u_div_x (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (w_div_start),
    .dividend_in  (r_sum_x),
    .divisor_in   (w_divisor),
    .quotient_out (w_quot_x),
    .done_out     (w_done_x)
  );

  centroid_divider #(.WIDTH(SUM_WIDTH)) u_div_y (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (w_div_start),
    .dividend_in  (r_sum_y),
    .divisor_in   (w_divisor),
    .quotient_out (w_quot_y),
    .done_out     (w_done_y)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_start   = 1'b0;
    w_empty_start = 1'b0;
    w_publish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (new_frame_in) begin
          if (r_cnt != '0) begin
            w_state_nxt = DIVIDE;
            w_div_start = 1'b1;
          end else begin
            w_state_nxt   = DONE;
            w_empty_start = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (w_done_x && w_done_y) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_publish   = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // An empty frame keeps the previous coordinates and only clears found_out.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mask_out           <= 1'b0;
      x_out              <= '0;
      y_out              <= '0;
      found_out          <= 1'b0;
      centroid_valid_out <= 1'b0;
      busy_out           <= 1'b0;
      overrun_out        <= 1'b0;
      r_div_path         <= 1'b0;
    end else begin
      mask_out           <= w_mask;
      centroid_valid_out <= w_publish;
      busy_out           <= (w_state_nxt != IDLE);
      overrun_out        <= new_frame_in && (r_state != IDLE);
      if (w_div_start) begin
        r_div_path <= 1'b1;
      end else if (w_empty_start) begin
        r_div_path <= 1'b0;
      end
      if (w_publish) begin
        found_out <= r_div_path;
        if (r_div_path) begin
          x_out <= w_quot_x[H_WIDTH-1:0];
          y_out <= w_quot_y[V_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_centroid_tracker.sv
// Self-checking bench: mask vector table plus scoreboarded frame sequences.
module tb_chroma_centroid_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [7:0]  y_in, cr_in, cb_in;
  logic        new_frame_in;
  logic [7:0]  cr_lo_in, cr_hi_in, y_min_in;
  logic        mask_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        found_out, centroid_valid_out, busy_out, overrun_out;

  chroma_centroid_tracker dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .valid_in           (valid_in),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .y_in               (y_in),
    .cr_in              (cr_in),
    .cb_in              (cb_in),
    .new_frame_in       (new_frame_in),
    .cr_lo_in           (cr_lo_in),
    .cr_hi_in           (cr_hi_in),
    .y_min_in           (y_min_in),
    .mask_out           (mask_out),
    .x_out              (x_out),
    .y_out              (y_out),
    .found_out          (found_out),
    .centroid_valid_out (centroid_valid_out),
    .busy_out           (busy_out),
    .overrun_out        (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int found;
  } exp_t;

  typedef struct {
    int yy;
    int cr;
    int lo;
    int hi;
    int ymin;
    bit v;
    bit exp;
  } mvec_t;

  exp_t   sb[$];
  int     ov_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;
  longint mx = 0, my = 0, mc = 0;
  int     last_x = 0, last_y = 0;
  int     busy_until = -1;
  exp_t   mon_e;
  int     mon_c;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard consumer for centroid results and overrun pulses.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (centroid_valid_out) begin
        if (sb.size() == 0) chk("unexpected_centroid_valid", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("centroid_cycle", cyc, mon_e.cyc);
          chk("centroid_x", x_out, mon_e.x);
          chk("centroid_y", y_out, mon_e.y);
          chk("centroid_found", found_out, mon_e.found);
        end
      end
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        mon_e = sb.pop_front();
        chk("centroid_missing", 0, 1);
      end
      if (overrun_out) begin
        if (ov_q.size() == 0) chk("unexpected_overrun", 1, 0);
        else begin
          mon_c = ov_q.pop_front();
          chk("overrun_cycle", cyc, mon_c);
        end
      end
      if (ov_q.size() > 0 && cyc > ov_q[0]) begin
        mon_c = ov_q.pop_front();
        chk("overrun_missing", 0, 1);
      end
    end
  end

  // Drive one pixel for one cycle and update the reference model.
  task automatic pix(input bit v, input int h, input int vv, input int yy, input int cr, input bit nf);
    bit m;
    valid_in     = v;
    hcount_in    = 11'(h);
    vcount_in    = 10'(vv);
    y_in         = 8'(yy);
    cr_in        = 8'(cr);
    cb_in        = 8'(h);
    new_frame_in = nf;
    m = v && (cr >= int'(cr_lo_in)) && (cr <= int'(cr_hi_in)) && (yy >= int'(y_min_in));
    if (nf) begin
      if (cyc > busy_until) begin
        if (mc != 0) begin
          last_x = int'((mx / mc) % 2048);
          last_y = int'((my / mc) % 1024);
          sb.push_back('{cyc + 35, last_x, last_y, 1});
          busy_until = cyc + 34;
        end else begin
          sb.push_back('{cyc + 2, last_x, last_y, 0});
          busy_until = cyc + 1;
        end
      end else begin
        ov_q.push_back(cyc + 1);
      end
      mx = m ? h : 0;
      my = m ? vv : 0;
      mc = m ? 1 : 0;
    end else if (m) begin
      mx += h;
      my += vv;
      mc += 1;
    end
    @(posedge clk_in);
    #1;
    new_frame_in = 1'b0;
    valid_in     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_thr(input int lo, input int hi, input int ymin);
    cr_lo_in = 8'(lo);
    cr_hi_in = 8'(hi);
    y_min_in = 8'(ymin);
  endtask

  initial begin
    mvec_t tbl[9];
    bit    prev_exp;

    tbl[0] = '{100, 100, 100, 150, 50, 1, 1};
    tbl[1] = '{100, 150, 100, 150, 50, 1, 1};
    tbl[2] = '{100,  99, 100, 150, 50, 1, 0};
    tbl[3] = '{100, 151, 100, 150, 50, 1, 0};
    tbl[4] = '{ 50, 120, 100, 150, 50, 1, 1};
    tbl[5] = '{ 49, 120, 100, 150, 50, 1, 0};
    tbl[6] = '{100, 120, 100, 150, 50, 0, 0};
    tbl[7] = '{100, 120, 150, 100, 50, 1, 0};
    tbl[8] = '{  0,   0,   0, 255,  0, 1, 1};

    rst_in = 1'b1;
    valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
    y_in = '0; cr_in = '0; cb_in = '0; new_frame_in = 1'b0;
    set_thr(100, 150, 50);
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_mask", mask_out, 0);
    chk("reset_x", x_out, 0);
    chk("reset_y", y_out, 0);
    chk("reset_found", found_out, 0);
    chk("reset_valid", centroid_valid_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_overrun", overrun_out, 0);
    rst_in = 1'b0;
    idle(2);

    // Threshold table: inclusive bounds, luma floor, qualifier, inverted window.
    prev_exp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_thr(tbl[i].lo, tbl[i].hi, tbl[i].ymin);
      fork
        pix(tbl[i].v, i + 1, 3, tbl[i].yy, tbl[i].cr, 0);
        begin
          #2;
          chk("mask_latency_hold", mask_out, prev_exp);
        end
      join
      chk("mask_value", mask_out, tbl[i].exp);
      prev_exp = tbl[i].exp;
    end
    set_thr(100, 150, 50);
    pix(0, 0, 0, 0, 0, 1);
    idle(40);

    // Four-pixel square around (11,21) with distractors that fail the key.
    pix(1, 10, 20, 100, 120, 0);
    pix(1, 300, 300, 100, 50, 0);
    pix(1, 12, 20, 100, 120, 0);
    pix(1, 10, 22, 100, 120, 0);
    pix(1, 700, 500, 10, 120, 0);
    pix(1, 12, 22, 100, 120, 0);
    pix(0, 0, 0, 0, 0, 1);
    chk("busy_during_divide", busy_out, 1);
    idle(36);
    chk("square_x", x_out, 11);
    chk("square_y", y_out, 21);
    chk("square_found", found_out, 1);
    chk("idle_after_result", busy_out, 0);

    // Empty frame: fast result, coordinates held.
    set_thr(200, 255, 0);
    for (int i = 0; i < 5; i++) pix(1, 40 + i, 50, 100, 100, 0);
    pix(0, 0, 0, 0, 0, 1);
    idle(5);
    chk("empty_found", found_out, 0);
    chk("empty_x_held", x_out, 11);
    chk("empty_y_held", y_out, 21);

    // Masked pixel coincident with the frame pulse belongs to the next frame.
    set_thr(100, 150, 50);
    pix(1, 30, 40, 100, 120, 0);
    pix(1, 5, 5, 100, 120, 1);
    idle(40);
    chk("coincident_prev_x", x_out, 30);
    pix(0, 0, 0, 0, 0, 1);
    idle(40);
    chk("coincident_x", x_out, 5);
    chk("coincident_y", y_out, 5);

    // Second frame pulse 10 cycles into a division.
    pix(1, 100, 200, 100, 120, 0);
    pix(1, 102, 202, 100, 120, 0);
    pix(0, 0, 0, 0, 0, 1);
    pix(1, 1, 1, 100, 120, 0);
    pix(1, 3, 3, 100, 120, 0);
    idle(7);
    pix(0, 0, 0, 0, 0, 1);
    pix(1, 50, 60, 100, 120, 0);
    pix(1, 54, 64, 100, 120, 0);
    idle(40);
    chk("overrun_first_x", x_out, 101);
    chk("overrun_first_y", y_out, 201);
    pix(0, 0, 0, 0, 0, 1);
    idle(40);
    chk("overrun_next_x", x_out, 52);
    chk("overrun_next_y", y_out, 62);

    // Reset 12 cycles into a division aborts it silently.
    pix(1, 400, 300, 100, 120, 0);
    pix(0, 0, 0, 0, 0, 1);
    idle(12);
    sb.delete();
    ov_q.delete();
    #2;
    rst_in = 1'b1;
    #1;
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_found", found_out, 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_valid", centroid_valid_out, 0);
    mx = 0; my = 0; mc = 0;
    last_x = 0; last_y = 0; busy_until = -1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(45);
    chk("abort_stays_idle", busy_out, 0);

    // Ten full-width rows, every pixel keyed.
    set_thr(0, 255, 0);
    for (int v = 0; v < 10; v++)
      for (int h = 0; h < 1280; h++)
        pix(1, h, v, 100, 100, 0);
    pix(0, 0, 0, 0, 0, 1);
    idle(40);
    chk("rows_x", x_out, 639);
    chk("rows_y", y_out, 4);
    chk("rows_found", found_out, 1);

    for (int i = 0; i < 100 && (sb.size() + ov_q.size()) > 0; i++) @(posedge clk_in);
    chk("scoreboard_drained", sb.size() + ov_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
